// File: rtl/stream_demux1to2_pkg.sv
// Shared types for the 1-to-2 stream demultiplexer.
// Destination encoding and select-to-onehot steering helper.
package stream_demux1to2_pkg;

   typedef enum logic {
      DST0 = 1'b0,
      DST1 = 1'b1
   } dest_e;

   function automatic logic [1:0] dest_onehot(input dest_e d);
      logic [1:0] oh;
      oh = 2'b00;
      unique case (d)
         DST0: oh = 2'b01;
         DST1: oh = 2'b10;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/stream_demux1to2_sync_fifo.sv
// Synchronous FIFO with registered count, cleared storage on reset.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == CNT_W'(DEPTH));
   assign level     = cnt_q;
   assign head_data = mem_q[rd_ptr_q];
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is cleared so the head reads zero straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/stream_demux1to2.sv
// One valid/ready stream steered per beat into two independently
// buffered output streams.
module stream_demux1to2
   import stream_demux1to2_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_select,
   output logic                     out0_valid,
   input  logic                     out0_ready,
   output logic [WIDTH-1:0]         out0_data,
   output logic [$clog2(DEPTH):0]   out0_level,
   output logic                     out1_valid,
   input  logic                     out1_ready,
   output logic [WIDTH-1:0]         out1_data,
   output logic [$clog2(DEPTH):0]   out1_level
);

   logic [1:0] sel_oh;
   logic       full0, full1;
   logic       empty0, empty1;
   logic       accept;

   assign sel_oh = dest_onehot(dest_e'(in_select));

   // Only the targeted FIFO gates acceptance; no pass-through on pop.
   assign in_ready   = ~rst & ~(sel_oh[1] ? full1 : full0);
   assign accept     = in_valid & in_ready;
   assign out0_valid = ~empty0;
   assign out1_valid = ~empty1;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
      .clk       (clk),
      .rst       (rst),
      .push      (accept & sel_oh[0]),
      .push_data (in_data),
      .pop       (out0_ready & out0_valid),
      .head_data (out0_data),
      .empty     (empty0),
      .full      (full0),
      .level     (out0_level)
   );

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
      .clk       (clk),
      .rst       (rst),
      .push      (accept & sel_oh[1]),
      .push_data (in_data),
      .pop       (out1_ready & out1_valid),
      .head_data (out1_data),
      .empty     (empty1),
      .full      (full1),
      .level     (out1_level)
   );

endmodule

// File: tb/tb_stream_demux1to2.sv
// Randomized bench for stream_demux1to2 against a queue-based model.
module tb_stream_demux1to2;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, in_select;
   logic [WIDTH-1:0] in_data;
   logic             out0_valid, out0_ready;
   logic [WIDTH-1:0] out0_data;
   logic [LW-1:0]    out0_level;
   logic             out1_valid, out1_ready;
   logic [WIDTH-1:0] out1_data;
   logic [LW-1:0]    out1_level;

   int checks = 0;
   int errors = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] got1[$];
   bit          rec1 = 0;

   always #5 clk = ~clk;

   stream_demux1to2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_select  (in_select),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out0_level (out0_level),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .out1_level (out1_level)
   );

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
      chk("out0_level", 32'(out0_level), 32'(q0.size()));
      chk("out1_level", 32'(out1_level), 32'(q1.size()));
      if (q0.size() > 0) chk("out0_data", out0_data, q0[0]);
      if (q1.size() > 0) chk("out1_data", out1_data, q1[0]);
      chk("level_bound", 32'(out0_level <= DEPTH && out1_level <= DEPTH), 32'd1);
   endtask

   // One clock: check in_ready, advance the model, check registered outputs.
   task automatic cycle(output bit acc);
      bit          exp_rdy, p0, p1, sel;
      logic [31:0] dat;
      #1;
      exp_rdy = in_select ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      acc = in_valid && exp_rdy;
      p0  = out0_ready && q0.size() > 0;
      p1  = out1_ready && q1.size() > 0;
      if (p1 && rec1) got1.push_back(out1_data);
      dat = in_data;
      sel = in_select;
      @(posedge clk);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
         if (sel) q1.push_back(dat);
         else     q0.push_back(dat);
      end
      #1;
      check_outputs();
   endtask

   task automatic drive(input bit v, input bit s, input logic [31:0] d,
                        input bit r0, input bit r1);
      in_valid   = v;
      in_select  = s;
      in_data    = d;
      out0_ready = r0;
      out1_ready = r1;
   endtask

   initial begin
      bit acc;
      bit tog;
      int i;
      int budget;

      rst = 1'b1;
      drive(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out0_valid", 32'(out0_valid), 32'd0);
      chk("rst_out0_data", out0_data, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_outputs();
      chk("post_rst_level", 32'(out0_level), 32'd0);

      // Asynchronous reset in mid-operation
      drive(1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);
      cycle(acc);
      chk("a5_head", out0_data, 32'hA5A5A5A5);
      in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("async_out0_valid", 32'(out0_valid), 32'd0);
      chk("async_in_ready", 32'(in_ready), 32'd0);
      q0.delete();
      q1.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_outputs();
      chk("rel_level", 32'(out0_level), 32'd0);
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // Single beat
      drive(1'b1, 1'b0, 32'h00000011, 1'b1, 1'b0);
      cycle(acc);
      chk("single_valid", 32'(out0_valid), 32'd1);
      chk("single_data", out0_data, 32'h00000011);
      chk("single_out1", 32'(out1_valid), 32'd0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      cycle(acc);

      // Backpressure isolation
      drive(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
      cycle(acc);
      drive(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
      cycle(acc);
      chk("bp_level", 32'(out0_level), 32'd2);
      drive(1'b1, 1'b0, 32'h9, 1'b0, 1'b0);
      #1;
      chk("bp_ready_sel0", 32'(in_ready), 32'd0);
      drive(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
      cycle(acc);
      chk("bp_out1_data", out1_data, 32'h3);
      chk("bp_out1_valid", 32'(out1_valid), 32'd1);

      // Full with simultaneous pop
      drive(1'b1, 1'b0, 32'h4, 1'b1, 1'b0);
      cycle(acc);
      chk("fullpop_acc", 32'(acc), 32'd0);
      chk("fullpop_head", out0_data, 32'h2);
      chk("fullpop_level", 32'(out0_level), 32'd1);
      drive(1'b1, 1'b0, 32'h4, 1'b0, 1'b0);
      cycle(acc);
      chk("refill_level", 32'(out0_level), 32'd2);

      // Drain both
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      repeat (4) cycle(acc);

      // Wrap and ordering on out1
      rec1   = 1;
      tog    = 0;
      i      = 0;
      budget = 200;
      while (i < 10 && budget > 0) begin
         drive(1'b1, 1'b1, 32'(i), 1'b1, tog);
         tog = ~tog;
         cycle(acc);
         if (acc) i++;
         budget--;
      end
      chk("wrap_sent", 32'(i), 32'd10);
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b1, 32'h0, 1'b1, tog);
         tog = ~tog;
         cycle(acc);
      end
      rec1 = 0;
      chk("wrap_count", 32'(got1.size()), 32'd10);
      for (int k = 0; k < got1.size(); k++) chk("wrap_order", got1[k], 32'(k));

      // Random soak
      for (int n = 0; n < 10000; n++) begin
         drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
               $urandom, bit'($urandom_range(0, 2) != 0),
               bit'($urandom_range(0, 3) == 0));
         cycle(acc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_demux1to2.md
Name: stream_demux1to2

Overview:
- Routes one valid/ready data stream to one of two destination streams, steered per beat by a select sideband. It is the sequential, flow-controlled counterpart of the 2-to-1 mux.
- Used wherever the sail-core datapath fans one producer out to two consumers, for example a writeback/bypass split.
- Each output has its own small FIFO, so one stalled consumer does not block beats headed to the other while its FIFO has space.

Parameters:
- WIDTH, 32, data width in bits (1..32).
- DEPTH, 2, entries per output FIFO (power of 2, at least 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous assertion, active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid and in_ready are both high.
- in_data  input  WIDTH  input payload.
- in_select  input  1  destination: 0 selects out0, 1 selects out1.
- out0_valid  output  1  out0 FIFO non-empty.
- out0_ready  input  1  consumer 0 pops the head.
- out0_data  output  WIDTH  head entry of out0 FIFO.
- out0_level  output  $clog2(DEPTH)+1  out0 occupancy.
- out1_valid, out1_ready, out1_data, out1_level: same as out0, for destination 1.

Behaviour:
- Reset (rst high, asynchronous):
  - All read/write pointers and counts go to 0.
  - outN_valid = 0, outN_level = 0, outN_data = 0 (storage cleared).
  - in_ready = 0 while rst is high.
  - A beat presented during reset is dropped. In-flight contents are discarded with no partial state retained.
- Input acceptance:
  - in_ready = !rst and !full(in_select), combinational from in_select and the registered count.
  - in_ready reflects only the selected FIFO. The other FIFO's fullness has no effect.
  - in_ready does not depend on outN_ready. There is no same-cycle pass-through, so a full FIFO rejects input even while it is being popped.
- Push: on an accepted beat, in_data is written at wr_ptr of the selected FIFO. Then wr_ptr+1 (modulo DEPTH) and count+1.
- Pop:
  - When outN_valid and outN_ready are both high, rd_ptr+1 (modulo DEPTH) and count-1.
  - outN_ready asserted while outN_valid = 0 is ignored.
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
- Latency: a beat accepted in cycle N is visible as outN_valid/outN_data in cycle N+1 at the earliest, so there is 1 cycle of minimum latency.
- Ordering: beats to the same destination leave in acceptance order. No ordering is guaranteed between out0 and out1.
- Data stability: outN_data and outN_valid stay stable while outN_valid is high and outN_ready is low.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits, so full is count == DEPTH and empty is count == 0.
- Boundary cases:
  - Full: no push; count never exceeds DEPTH.
  - Empty: no pop; count never underflows.
  - in_select changing while in_valid is high and in_ready is low is legal. in_ready re-evaluates against the new target.
- outN_level equals the registered count, with no lookahead.

Decomposition:
- No shared package is required. The only localparam, PTR_W = $clog2(DEPTH), stays local.
- One natural sub-module, sync_fifo: parameters WIDTH and DEPTH; ports clk, rst, push, push_data, pop, head_data, empty, full, level.
- Instantiate sync_fifo twice. The top level holds only the select steering and the ready logic.

Test Plan:
- Reset mid-operation: push 0xA5A5A5A5 to out0, then assert rst asynchronously between clock edges -> out0_valid falls to 0 immediately; after release, level = 0 and in_ready = 1.
- Single beat: send 0x00000011 with select = 0, out0_ready = 1 -> out0_valid high in the next cycle with data 0x00000011; out1_valid stays 0.
- Backpressure isolation (DEPTH = 2): out0_ready = 0, push 0x1 and 0x2 to out0 -> out0_level = 2 and in_ready = 0 for select = 0; a push of 0x3 with select = 1 is still accepted and out1_data = 0x3.
- Full with simultaneous pop: out0 full, out0_ready = 1, in_valid with select = 0 -> in_ready = 0 that cycle and 0x1 pops; the next cycle accepts the beat and level returns to 2.
- Wrap and ordering: stream 0..9 to out1 with out1_ready toggling every cycle -> out1 emits 0..9 in order with no loss or duplication.
- Random soak: random select, valid and readies for 10k cycles -> a scoreboard per destination matches, and level never exceeds DEPTH.
